// File: rtl/jr_pkg.sv
// Shared types and constants for the ring/Johnson sequence monitor.
package jr_pkg;

  // Monitor lock state
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  // Classification of the current sample against the previous one
  typedef enum logic [1:0] {
    ADV  = 2'd0,
    HOLD = 2'd1,
    SKIP = 2'd2,
    ILL  = 2'd3
  } outcome_e;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

endpackage

// File: rtl/jr_code_decode.sv
// Combinational decode of a ring or Johnson code into legality and phase index.
module jr_code_decode
  import jr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]             code,
  input  logic                         j_r,
  output logic                         legal,
  output logic [$clog2(2*WIDTH)-1:0]   idx
);

  localparam int PW = $clog2(2*WIDTH);

  // Code word of phase k: Johnson fills ones from the LSB then zeros from the LSB; ring is one-hot
  function automatic logic [WIDTH-1:0] pattern(input int k, input logic mode);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (mode == MODE_JOHNSON) begin
        p[b] = (k <= WIDTH) ? (b < k) : (b >= (k - WIDTH));
      end else begin
        p[b] = (b == k);
      end
    end
    return p;
  endfunction

  // Match the code against every phase pattern of the selected mode
  always_comb begin
    logic hit;
    legal = 1'b0;
    idx   = '0;
    for (int k = 0; k < 2*WIDTH; k++) begin
      hit   = ((j_r == MODE_JOHNSON) || (k < WIDTH)) && (code == pattern(k, j_r));
      legal = legal | hit;
      idx   = hit ? PW'(k) : idx;
    end
  end

endmodule

// File: rtl/jr_seq_monitor.sv
// Sequence monitor for a ring/Johnson counter: decode, lock tracking, error and wrap pulses.
module jr_seq_monitor
  import jr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        j_r,
  input  logic [WIDTH-1:0]            cnt_in,
  output logic [$clog2(2*WIDTH)-1:0]  phase,
  output logic                        phase_vld,
  output logic                        locked,
  output logic                        err,
  output logic                        wrap,
  output logic [ERR_W-1:0]            err_cnt
);

  localparam int          PW       = $clog2(2*WIDTH);
  localparam logic [3:0]  LOCK_TGT = 4'(LOCK_CNT);

  state_e            state_q;
  logic [3:0]        run_q;
  logic [WIDTH-1:0]  prev_q;
  logic              mode_q;
  logic              seen_q;
  logic [PW-1:0]     phase_q;
  logic              phase_vld_q;
  logic              locked_q;
  logic              err_q;
  logic              wrap_q;
  logic [ERR_W-1:0]  err_cnt_q;

  logic              cur_legal_s;
  logic [PW-1:0]     cur_idx_s;
  logic              prev_legal_s;
  logic [PW-1:0]     prev_idx_s;
  logic [PW-1:0]     last_idx_s;
  logic [PW-1:0]     succ_idx_s;
  outcome_e          outcome_s;
  logic              mode_chg_s;
  logic              err_ev_s;
  logic              wrap_ev_s;
  logic [3:0]        run_inc_s;

  jr_code_decode #(.WIDTH(WIDTH)) u_dec_cur (
    .code  (cnt_in),
    .j_r   (j_r),
    .legal (cur_legal_s),
    .idx   (cur_idx_s)
  );

  jr_code_decode #(.WIDTH(WIDTH)) u_dec_prev (
    .code  (prev_q),
    .j_r   (j_r),
    .legal (prev_legal_s),
    .idx   (prev_idx_s)
  );

  // Classify the current sample relative to the previous one and derive event pulses
  always_comb begin
    last_idx_s = (j_r == MODE_JOHNSON) ? PW'(2*WIDTH - 1) : PW'(WIDTH - 1);
    succ_idx_s = (prev_idx_s == last_idx_s) ? '0 : (prev_idx_s + PW'(1));
    if (!cur_legal_s) begin
      outcome_s = ILL;
    end else if (cnt_in == prev_q) begin
      outcome_s = HOLD;
    end else if (prev_legal_s && (cur_idx_s == succ_idx_s)) begin
      outcome_s = ADV;
    end else begin
      outcome_s = SKIP;
    end
    // A mode flip is only meaningful once a sample in some mode has been seen
    mode_chg_s = seen_q && (j_r != mode_q);
    err_ev_s   = !mode_chg_s && (state_q == LOCKED) && ((outcome_s == SKIP) || (outcome_s == ILL));
    wrap_ev_s  = !mode_chg_s && (state_q == LOCKED) && (outcome_s == ADV) && (cur_idx_s == '0);
    run_inc_s  = run_q + 4'd1;
  end

  // Lock FSM, sample history and registered outputs
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= UNLOCKED;
      run_q       <= 4'd0;
      prev_q      <= '0;
      mode_q      <= 1'b0;
      seen_q      <= 1'b0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      prev_q      <= cnt_in;
      mode_q      <= j_r;
      seen_q      <= 1'b1;
      phase_vld_q <= cur_legal_s;
      phase_q     <= cur_legal_s ? cur_idx_s : phase_q;
      err_q       <= err_ev_s;
      wrap_q      <= wrap_ev_s;
      if (err_ev_s && (err_cnt_q != {ERR_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end else begin
        err_cnt_q <= err_cnt_q;
      end

      if (mode_chg_s) begin
        state_q  <= UNLOCKED;
        run_q    <= 4'd0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          UNLOCKED: begin
            state_q  <= cur_legal_s ? ACQUIRE : UNLOCKED;
            run_q    <= 4'd0;
            locked_q <= 1'b0;
          end
          ACQUIRE: begin
            locked_q <= 1'b0;
            case (outcome_s)
              ADV: begin
                run_q <= run_inc_s;
                if (run_inc_s == LOCK_TGT) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end else begin
                  state_q  <= ACQUIRE;
                end
              end
              HOLD: begin
                state_q <= ACQUIRE;
              end
              SKIP: begin
                state_q <= ACQUIRE;
                run_q   <= 4'd0;
              end
              ILL: begin
                state_q <= UNLOCKED;
                run_q   <= 4'd0;
              end
              default: begin
                state_q <= UNLOCKED;
                run_q   <= 4'd0;
              end
            endcase
          end
          LOCKED: begin
            case (outcome_s)
              ADV, HOLD: begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
              SKIP: begin
                state_q  <= ACQUIRE;
                run_q    <= 4'd0;
                locked_q <= 1'b0;
              end
              ILL: begin
                state_q  <= UNLOCKED;
                run_q    <= 4'd0;
                locked_q <= 1'b0;
              end
              default: begin
                state_q  <= UNLOCKED;
                run_q    <= 4'd0;
                locked_q <= 1'b0;
              end
            endcase
          end
          default: begin
            state_q  <= UNLOCKED;
            run_q    <= 4'd0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign phase     = phase_q;
  assign phase_vld = phase_vld_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign wrap      = wrap_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jr_seq_monitor.sv
// Bench for jr_seq_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_jr_seq_monitor;

  localparam int W  = 4;
  localparam int LK = 3;
  localparam int EW = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          j_r;
  logic [W-1:0]  cnt_in;
  logic [PW-1:0] phase;
  logic          phase_vld;
  logic          locked;
  logic          err;
  logic          wrap;
  logic [EW-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  jr_seq_monitor #(.WIDTH(W), .LOCK_CNT(LK), .ERR_W(EW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .j_r       (j_r),
    .cnt_in    (cnt_in),
    .phase     (phase),
    .phase_vld (phase_vld),
    .locked    (locked),
    .err       (err),
    .wrap      (wrap),
    .err_cnt   (err_cnt)
  );

  // Behavioural model state: 0 = unlocked, 1 = acquiring, 2 = locked
  int m_state, m_run, m_prev, m_mode, m_seen;
  int m_phase, m_vld, m_err, m_wrap, m_cnt;

  function automatic int mper(input int jr);
    return (jr != 0) ? 2 * W : W;
  endfunction

  // Code word of phase k in the given mode, as plain arithmetic
  function automatic int mpat(input int k, input int jr);
    if (jr == 0) return (1 << k);
    if (k <= W) return (1 << k) - 1;
    return ((1 << W) - 1) & ~((1 << (k - W)) - 1);
  endfunction

  // Phase of a code in the given mode, or -1 if the code is not in the sequence
  function automatic int mfind(input int c, input int jr);
    int ix;
    ix = -1;
    for (int k = 0; k < mper(jr); k++) begin
      if (mpat(k, jr) == c) ix = k;
    end
    return ix;
  endfunction

  task automatic model_step(input int rst, input int code, input int jr);
    int ix, pix;
    bit chg, ill, hold, adv, skip;
    if (rst != 0) begin
      m_state = 0; m_run = 0; m_prev = 0; m_mode = 0; m_seen = 0;
      m_phase = 0; m_vld = 0; m_err = 0; m_wrap = 0; m_cnt = 0;
      return;
    end
    ix   = mfind(code, jr);
    pix  = mfind(m_prev, jr);
    chg  = (m_seen != 0) && (jr != m_mode);
    ill  = (ix < 0);
    hold = !ill && (code == m_prev);
    adv  = !ill && !hold && (pix >= 0) && (ix == (pix + 1) % mper(jr));
    skip = !ill && !hold && !adv;
    m_err  = 0;
    m_wrap = 0;
    if (chg) begin
      m_state = 0; m_run = 0;
    end else if (m_state == 0) begin
      if (!ill) begin m_state = 1; m_run = 0; end
    end else if (m_state == 1) begin
      if (adv) begin
        m_run++;
        if (m_run == LK) m_state = 2;
      end else if (skip) begin
        m_run = 0;
      end else if (ill) begin
        m_state = 0; m_run = 0;
      end
    end else begin
      if (skip) begin
        m_err = 1; m_state = 1; m_run = 0;
      end else if (ill) begin
        m_err = 1; m_state = 0; m_run = 0;
      end else if (adv && ix == 0) begin
        m_wrap = 1;
      end
    end
    if (m_err != 0 && m_cnt < (1 << EW) - 1) m_cnt++;
    if (!ill) m_phase = ix;
    m_vld  = ill ? 0 : 1;
    m_prev = code;
    m_mode = jr;
    m_seen = 1;
  endtask

  // Compare every DUT output against the model once per cycle, away from the active edge
  always @(negedge clk) begin
    logic [8:0] act, exp;
    if (chk_en) begin
      act = {phase, phase_vld, locked, err, wrap, err_cnt};
      exp = {m_phase[PW-1:0], m_vld[0], (m_state == 2), m_err[0], m_wrap[0], m_cnt[EW-1:0]};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t {phase,vld,locked,err,wrap,err_cnt} got %b expected %b",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Apply one sample, advance one clock, update the model, return at the falling edge
  task automatic step(input int rst, input int code, input int jr);
    rstn   = rst[0];
    cnt_in = code[W-1:0];
    j_r    = jr[0];
    @(posedge clk);
    model_step(rst, code, jr);
    @(negedge clk);
  endtask

  initial begin
    int r, code, rst, jr, cur;
    rstn = 1'b1; j_r = 1'b1; cnt_in = '0;

    // Reset held two cycles
    step(1, 0, 1);
    chk_en = 1'b1;
    step(1, 0, 1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_vld", int'(phase_vld), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_errcnt", int'(err_cnt), 0);

    // Johnson acquire and lock
    step(0, 4'b0000, 1);
    step(0, 4'b0001, 1);
    step(0, 4'b0011, 1);
    chk("acq_not_yet", int'(locked), 0);
    step(0, 4'b0111, 1);
    chk("lock_johnson", int'(locked), 1);
    chk("lock_phase", int'(phase), 3);

    // Johnson wrap
    step(0, 4'b1111, 1);
    step(0, 4'b1110, 1);
    step(0, 4'b1100, 1);
    step(0, 4'b1000, 1);
    chk("pre_wrap", int'(wrap), 0);
    step(0, 4'b0000, 1);
    chk("wrap_pulse", int'(wrap), 1);
    chk("wrap_phase", int'(phase), 0);
    step(0, 4'b0001, 1);
    chk("wrap_once", int'(wrap), 0);

    // Stall while locked
    step(0, 4'b0011, 1);
    for (int i = 0; i < 5; i++) step(0, 4'b0011, 1);
    chk("hold_locked", int'(locked), 1);
    chk("hold_noerr", int'(err), 0);

    // Illegal Johnson code
    step(0, 4'b0101, 1);
    chk("ill_err", int'(err), 1);
    chk("ill_unlock", int'(locked), 0);
    chk("ill_vld", int'(phase_vld), 0);
    chk("ill_phase_held", int'(phase), 2);
    chk("ill_errcnt", int'(err_cnt), 1);

    // Relock in Johnson, then flip to ring mode
    step(0, 4'b0011, 1);
    step(0, 4'b0111, 1);
    step(0, 4'b1111, 1);
    step(0, 4'b1110, 1);
    chk("relock_j", int'(locked), 1);
    step(0, 4'b0001, 0);
    chk("mode_unlock", int'(locked), 0);
    chk("mode_noerr", int'(err), 0);

    // Ring lock, skip error, relock
    step(0, 4'b0010, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b1000, 0);
    step(0, 4'b0001, 0);
    chk("lock_ring", int'(locked), 1);
    step(0, 4'b0010, 0);
    step(0, 4'b1000, 0);
    chk("skip_err", int'(err), 1);
    chk("skip_unlock", int'(locked), 0);
    chk("skip_errcnt", int'(err_cnt), 2);
    step(0, 4'b0001, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0100, 0);
    chk("relock_ring", int'(locked), 1);

    // Saturate the 2-bit error counter
    step(0, 4'b1111, 0);
    chk("sat_err3", int'(err_cnt), 3);
    step(0, 4'b1000, 0);
    step(0, 4'b0001, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b0000, 0);
    chk("sat_err_pulse", int'(err), 1);
    chk("sat_hold", int'(err_cnt), 3);

    // Mode change together with an illegal code while locked: no error
    step(0, 4'b0001, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b1000, 0);
    chk("relock_ring2", int'(locked), 1);
    step(0, 4'b0101, 1);
    chk("chg_ill_noerr", int'(err), 0);
    chk("chg_ill_unlock", int'(locked), 0);

    // Reset while locked
    step(0, 4'b0001, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b1000, 0);
    step(0, 4'b0001, 0);
    chk("relock_ring3", int'(locked), 1);
    step(1, 4'b0010, 0);
    chk("rst_mid_locked", int'(locked), 0);
    chk("rst_mid_errcnt", int'(err_cnt), 0);

    // Randomized traffic, mostly well-formed so locks are reached often
    jr = 1; cur = 0;
    for (int i = 0; i < 4000; i++) begin
      r   = int'($urandom_range(0, 99));
      rst = 0;
      if (r < 70) begin
        cur  = (cur + 1) % mper(jr);
        code = mpat(cur, jr);
      end else if (r < 80) begin
        code = mpat(cur, jr);
      end else if (r < 87) begin
        cur  = (cur + int'($urandom_range(2, mper(jr) - 1))) % mper(jr);
        code = mpat(cur, jr);
      end else if (r < 94) begin
        do code = int'($urandom_range(0, 15)); while (mfind(code, jr) >= 0);
      end else if (r < 98) begin
        jr   = 1 - jr;
        cur  = int'($urandom_range(0, mper(jr) - 1));
        code = mpat(cur, jr);
      end else begin
        rst  = 1;
        code = int'($urandom_range(0, 15));
      end
      step(rst, code, jr);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jr_seq_monitor.md
# jr_seq_monitor

Sequence monitor placed directly downstream of the ring/Johnson counter. It samples the counter's `out` bus every clock and checks the value against the active code (`j_r`). It decodes the value into a binary phase index, declares lock after a run of correct successive codes, and flags illegal codes or skipped codes. It also pulses once per completed cycle and keeps a saturating error count.

## Interface
Parameters:
- `WIDTH`, 4: counter bus width, ≥ 2.
- `LOCK_CNT`, 3: consecutive correct advances required to lock, 1..15.
- `ERR_W`, 8: error counter width.

Ports (`PW` = $clog2(2*WIDTH)):
- `clk` in 1: single clock, all logic on rising edge.
- `rstn` in 1: synchronous, active-high reset. The name follows codebase convention; polarity is high.
- `j_r` in 1: code select. 1 = Johnson, 0 = ring.
- `cnt_in` in WIDTH: counter output.
- `phase` out PW: decoded phase of last sampled code.
- `phase_vld` out 1: `cnt_in` sampled last edge was a legal code.
- `locked` out 1: monitor is in LOCKED.
- `err` out 1: one-cycle pulse on a sequence error.
- `wrap` out 1: one-cycle pulse when the last phase advances to phase 0 while locked.
- `err_cnt` out ERR_W: saturating count of `err` pulses.

## Operation
- Ring code sequence, phase 0..WIDTH-1: 0…01 → 0…10 → … → 10…0 → 0…01 (one-hot, shift left). Any other value is illegal.
- Johnson code sequence, phase 0..2*WIDTH-1: 0000 → 0001 → 0011 → 0111 → 1111 → 1110 → 1100 → 1000 → 0000 (WIDTH=4). Ones fill from the LSB, then zeros fill from the LSB. Other values are illegal.
- Each edge, the current code is compared with the previous sample `prev`. Outcomes:
  - ADV: legal and equal to the successor of `prev`.
  - HOLD: equal to `prev`. This is a stall; it is not progress and not an error.
  - SKIP: legal, but neither ADV nor HOLD.
  - ILL: illegal code.
- FSM states are UNLOCKED, ACQUIRE and LOCKED; `run` counts ADVs.
  - UNLOCKED: legal code → ACQUIRE, `run`=0. Illegal → stay, no `err`.
  - ACQUIRE: ADV → `run`++, and when `run` reaches LOCK_CNT → LOCKED. HOLD → stay. SKIP → `run`=0, stay, no `err`. ILL → UNLOCKED, no `err`.
  - LOCKED: ADV or HOLD → stay. SKIP → `err`, ACQUIRE, `run`=0. ILL → `err`, UNLOCKED.
- A change of `j_r` between two samples forces UNLOCKED with no `err`. That edge's code is evaluated as the first sample in the new mode.
- `err_cnt` increments on each `err` and saturates at all-ones. It clears only on reset.
- When `phase_vld`=0, `phase` holds its prior value.

## Timing
- All outputs are registered. A code presented before edge k is reflected in the outputs after edge k (latency 1).
- `locked` rises on the same edge that the LOCK_CNT-th ADV is sampled.
- `wrap` asserts on the edge that samples the ADV from the last phase to phase 0, only if the FSM is LOCKED before that edge.
- Reset has priority over all events:
  - Outputs after reset: `phase`=0, `phase_vld`=0, `locked`=0, `err`=0, `wrap`=0, `err_cnt`=0.
  - Internal state after reset: FSM=UNLOCKED, `prev`=0, `run`=0.
  - Reset mid-lock drops `locked` on the next edge.
- A simultaneous `j_r` change and ILL in LOCKED → UNLOCKED with no `err`, because the mode change wins.

## Structure
- Package `jr_pkg`:
  - FSM state enum `{UNLOCKED, ACQUIRE, LOCKED}`.
  - Compare outcome enum `{ADV, HOLD, SKIP, ILL}`.
  - Mode constants `MODE_RING`=0 and `MODE_JOHNSON`=1.
- Sub-module `jr_code_decode` (combinational, parameter WIDTH):
  - Inputs: `code`, `j_r`.
  - Outputs: `legal`, `idx` [PW].
  - Instantiated twice, once for the current code and once for `prev`.
- Top level holds the FSM, `prev`, `run`, the successor compare and the counters.

## Test plan
- Reset held 2 cycles → all outputs 0. Release, drive Johnson 0000,0001,0011,0111 → `locked`=1 after the 4th sample (3 ADVs), `phase`=3.
- Locked Johnson, drive 1000 then 0000 → `wrap`=1 for exactly one cycle after the 0000 sample, `phase`=0.
- Locked ring, WIDTH=4, drive 0010 then 1000 (skip) → `err` pulse, `locked`=0, `err_cnt`=1. Then 0001,0010,0100 → relock.
- Locked Johnson, drive 0101 → `err`, UNLOCKED, `phase_vld`=0, `phase` unchanged.
- Hold `cnt_in` at 0011 for 5 cycles while locked → `locked` stays 1, no `err`. Toggle `j_r` mid-lock → `locked`=0 next edge, no `err`.
- With ERR_W=2, force 5 errors → `err_cnt` saturates at 3. Assert `rstn` while locked → `err_cnt`=0 and `locked`=0 after one edge.
